// File: rtl/flyer_swarm_move_pkg.sv
// Shared types and constants for the flyer swarm: channel FSM states, LFSR constants, timer helpers.
package flyer_pkg;

  typedef enum logic [1:0] {
    FLY_WAIT = 2'd0,
    FLY_FLY  = 2'd1,
    FLY_HIT  = 2'd2
  } flyer_state_t;

  localparam int unsigned MAX_FLYERS   = 8;
  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned TIMER_W      = 10;
  localparam int unsigned RESPAWN_BASE = 64;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // One Galois shift: output bit 0 folds back through the tap mask.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  // Respawn delay after escape or explosion: 64 + 2*sample frames.
  function automatic logic [TIMER_W-1:0] respawn_delay(input logic [SAMPLE_W-1:0] s);
    return TIMER_W'(RESPAWN_BASE) + TIMER_W'({s, 1'b0});
  endfunction

endpackage

// File: rtl/flyer_swarm_move_channel.sv
// One flyer: spawn-delay timer, WAIT/FLY/HIT state machine and fixed-point position accumulators.
module flyer_channel
  import flyer_pkg::*;
#(
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned FRAC_BITS   = 6,
  parameter int          X_SPEED     = -120,
  parameter int          Y_SPEED     = 70,
  parameter int          SPAWN_X     = 680,
  parameter int          SPAWN_Y     = 60,
  parameter int          TOP_EDGE    = 20,
  parameter int          BOTTOM_EDGE = 180,
  parameter int          LEFT_EDGE   = -50,
  parameter int unsigned FIRST_TIMER = 100,
  parameter int unsigned HIT_FRAMES  = 12,
  parameter int unsigned FLIP_THRESH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_sof,
  input  logic                      i_pause,
  input  logic                      i_hit,
  input  logic [SAMPLE_W-1:0]       i_sample,
  output logic signed [COORD_W-1:0] o_top_left_x,
  output logic signed [COORD_W-1:0] o_top_left_y,
  output logic                      o_active,
  output logic                      o_hit_anim,
  output logic                      o_escaped_pulse,
  output logic                      o_killed_pulse
);

  localparam int unsigned ACC_W = COORD_W + FRAC_BITS + 1;
  localparam int unsigned HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  localparam logic signed [ACC_W-1:0] SPAWN_X_ACC = ACC_W'(SPAWN_X) <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] SPAWN_Y_ACC = ACC_W'(SPAWN_Y) <<< FRAC_BITS;
  localparam logic signed [ACC_W-1:0] X_STEP      = ACC_W'(X_SPEED);
  localparam logic signed [ACC_W-1:0] Y_STEP      = ACC_W'(Y_SPEED);
  localparam logic signed [ACC_W-1:0] TOP_LIM     = ACC_W'(TOP_EDGE);
  localparam logic signed [ACC_W-1:0] BOT_LIM     = ACC_W'(BOTTOM_EDGE);
  localparam logic signed [ACC_W-1:0] LEFT_LIM    = ACC_W'(LEFT_EDGE);

  flyer_state_t             r_state, w_state_nxt;
  logic [TIMER_W-1:0]       r_timer, w_timer_nxt;
  logic [HIT_W-1:0]         r_hit_cnt, w_hit_cnt_nxt;
  logic signed [ACC_W-1:0]  r_x, w_x_nxt;
  logic signed [ACC_W-1:0]  r_y, w_y_nxt;
  logic                     r_up, w_up_nxt;
  logic                     r_active, r_hit_anim, r_esc, r_kill;
  logic                     w_esc_nxt, w_kill_nxt;

  logic                     w_frame;
  logic signed [ACC_W-1:0]  w_x_step, w_x_new_px, w_y_px, w_y_step;
  logic                     w_flip, w_up_fly;

  assign w_frame    = i_sof & ~i_pause;
  assign w_x_step   = r_x + X_STEP;
  assign w_x_new_px = w_x_step >>> FRAC_BITS;
  assign w_y_px     = r_y >>> FRAC_BITS;
  assign w_flip     = ({1'b0, i_sample} < 9'(FLIP_THRESH));

  // Edge bounce overrides the random flip; direction is chosen before the Y step.
  assign w_up_fly = (w_y_px < TOP_LIM) ? 1'b0 :
                    (w_y_px > BOT_LIM) ? 1'b1 :
                    w_flip             ? ~r_up : r_up;
  assign w_y_step = w_up_fly ? (r_y - Y_STEP) : (r_y + Y_STEP);

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_hit_cnt_nxt = r_hit_cnt;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_up_nxt      = r_up;
    w_esc_nxt     = 1'b0;
    w_kill_nxt    = 1'b0;
    unique case (r_state)
      FLY_WAIT: begin
        if (w_frame) begin
          if (r_timer == '0) w_state_nxt = FLY_FLY;
          else               w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end
      FLY_FLY: begin
        // A hit wins over a same-cycle frame strobe, so the position freezes where it was.
        if (i_hit && !i_pause) begin
          w_state_nxt   = FLY_HIT;
          w_hit_cnt_nxt = HIT_W'(HIT_FRAMES - 1);
          w_kill_nxt    = 1'b1;
        end else if (w_frame) begin
          w_x_nxt  = w_x_step;
          w_y_nxt  = w_y_step;
          w_up_nxt = w_up_fly;
          if (w_x_new_px <= LEFT_LIM) begin
            w_state_nxt = FLY_WAIT;
            w_esc_nxt   = 1'b1;
            w_timer_nxt = respawn_delay(i_sample);
            w_x_nxt     = SPAWN_X_ACC;
            w_y_nxt     = SPAWN_Y_ACC;
            w_up_nxt    = 1'b0;
          end
        end
      end
      FLY_HIT: begin
        if (w_frame) begin
          if (r_hit_cnt == '0) begin
            w_state_nxt = FLY_WAIT;
            w_timer_nxt = respawn_delay(i_sample);
            w_x_nxt     = SPAWN_X_ACC;
            w_y_nxt     = SPAWN_Y_ACC;
            w_up_nxt    = 1'b0;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt - HIT_W'(1);
          end
        end
      end
      default: w_state_nxt = FLY_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= FLY_WAIT;
      r_timer    <= TIMER_W'(FIRST_TIMER);
      r_hit_cnt  <= '0;
      r_x        <= SPAWN_X_ACC;
      r_y        <= SPAWN_Y_ACC;
      r_up       <= 1'b0;
      r_active   <= 1'b0;
      r_hit_anim <= 1'b0;
      r_esc      <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_hit_cnt  <= w_hit_cnt_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_up       <= w_up_nxt;
      r_active   <= (w_state_nxt == FLY_FLY);
      r_hit_anim <= (w_state_nxt == FLY_HIT);
      r_esc      <= w_esc_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  assign o_top_left_x    = COORD_W'(r_x >>> FRAC_BITS);
  assign o_top_left_y    = COORD_W'(r_y >>> FRAC_BITS);
  assign o_active        = r_active;
  assign o_hit_anim      = r_hit_anim;
  assign o_escaped_pulse = r_esc;
  assign o_killed_pulse  = r_kill;

endmodule

// File: rtl/flyer_swarm_move.sv
// Flyer swarm top: shared frame-rate LFSR, per-channel random sample slicing, one flyer_channel each.
module flyer_swarm_move
  import flyer_pkg::*;
#(
  parameter int unsigned NUM_FLYERS  = 4,
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned FRAC_BITS   = 6,
  parameter int          X_SPEED     = -120,
  parameter int          Y_SPEED     = 70,
  parameter int          START_TLX   = 680,
  parameter int          START_TLY   = 60,
  parameter int          Y_STEP      = 40,
  parameter int          TOP_EDGE    = 20,
  parameter int          BOTTOM_EDGE = 180,
  parameter int          LEFT_EDGE   = -50,
  parameter int unsigned FIRST_DELAY = 100,
  parameter int unsigned HIT_FRAMES  = 12,
  parameter int unsigned FLIP_THRESH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            startOfFrame,
  input  logic                            pause,
  input  logic [10:0]                     RNG,
  input  logic [NUM_FLYERS-1:0]           hit,
  output logic [NUM_FLYERS*COORD_W-1:0]   topLeftX,
  output logic [NUM_FLYERS*COORD_W-1:0]   topLeftY,
  output logic [NUM_FLYERS-1:0]           flyerActive,
  output logic [NUM_FLYERS-1:0]           flyerHitAnim,
  output logic [NUM_FLYERS-1:0]           escapedPulse,
  output logic [NUM_FLYERS-1:0]           killedPulse
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_mix;

  // The LFSR keeps running through pause so the random sequence never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_lfsr <= LFSR_SEED;
    else if (startOfFrame) r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_mix = r_lfsr ^ {RNG, 5'b0};

  for (genvar i = 0; i < int'(NUM_FLYERS); i++) begin : g_ch
    localparam int unsigned LSB = (i % 2) * SAMPLE_W;
    logic [SAMPLE_W-1:0] w_sample;
    assign w_sample = w_mix[LSB +: SAMPLE_W];

    flyer_channel #(
      .COORD_W     (COORD_W),
      .FRAC_BITS   (FRAC_BITS),
      .X_SPEED     (X_SPEED),
      .Y_SPEED     (Y_SPEED),
      .SPAWN_X     (START_TLX),
      .SPAWN_Y     (START_TLY + i * Y_STEP),
      .TOP_EDGE    (TOP_EDGE),
      .BOTTOM_EDGE (BOTTOM_EDGE),
      .LEFT_EDGE   (LEFT_EDGE),
      .FIRST_TIMER (FIRST_DELAY + 16 * i),
      .HIT_FRAMES  (HIT_FRAMES),
      .FLIP_THRESH (FLIP_THRESH)
    ) u_channel (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_sof           (startOfFrame),
      .i_pause         (pause),
      .i_hit           (hit[i]),
      .i_sample        (w_sample),
      .o_top_left_x    (topLeftX[i*COORD_W +: COORD_W]),
      .o_top_left_y    (topLeftY[i*COORD_W +: COORD_W]),
      .o_active        (flyerActive[i]),
      .o_hit_anim      (flyerHitAnim[i]),
      .o_escaped_pulse (escapedPulse[i]),
      .o_killed_pulse  (killedPulse[i])
    );
  end

endmodule

// File: tb/tb_flyer_swarm_move.sv
// Scoreboard bench for flyer_swarm_move: a frame-level reference model predicts every output each cycle.
module tb_flyer_swarm_move;

  localparam int NF = 4, CW = 11, FB = 6;
  localparam int XS = -120, YS = 70, SX = 680, SY = 60, YSTEP = 40;
  localparam int TOP = 20, BOT = 70, LEFT = -50, FD = 100, HF = 12, FT = 64;
  localparam int FRAME_CYC = 4;

  logic                clk = 1'b0;
  logic                reset, startOfFrame, pause;
  logic [10:0]         RNG;
  logic [NF-1:0]       hit;
  logic [NF*CW-1:0]    topLeftX, topLeftY;
  logic [NF-1:0]       flyerActive, flyerHitAnim, escapedPulse, killedPulse;

  always #5 clk = ~clk;

  flyer_swarm_move #(
    .NUM_FLYERS (NF), .COORD_W (CW), .FRAC_BITS (FB), .X_SPEED (XS), .Y_SPEED (YS),
    .START_TLX (SX), .START_TLY (SY), .Y_STEP (YSTEP), .TOP_EDGE (TOP), .BOTTOM_EDGE (BOT),
    .LEFT_EDGE (LEFT), .FIRST_DELAY (FD), .HIT_FRAMES (HF), .FLIP_THRESH (FT)
  ) dut (
    .clk (clk), .reset (reset), .startOfFrame (startOfFrame), .pause (pause), .RNG (RNG),
    .hit (hit), .topLeftX (topLeftX), .topLeftY (topLeftY), .flyerActive (flyerActive),
    .flyerHitAnim (flyerHitAnim), .escapedPulse (escapedPulse), .killedPulse (killedPulse)
  );

  typedef struct packed {
    logic [NF*CW-1:0] x;
    logic [NF*CW-1:0] y;
    logic [NF-1:0]    act;
    logic [NF-1:0]    anim;
    logic [NF-1:0]    esc;
    logic [NF-1:0]    kill;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e, mon_a;
  int    checks = 0, errors = 0;
  int    esc0_seen = 0, kill0_seen = 0, y_over = 0;

  // Reference model: 0=waiting, 1=flying, 2=exploding; positions in 1/64-pixel units.
  int          m_st[NF], m_tmr[NF], m_left[NF], m_x[NF], m_y[NF], m_dir[NF];
  bit          m_esc[NF], m_kill[NF];
  logic [15:0] m_lfsr;

  function automatic void respawn(int i, int samp);
    m_st[i]  = 0;
    m_tmr[i] = 64 + 2 * samp;
    m_x[i]   = SX * (1 << FB);
    m_y[i]   = (SY + i * YSTEP) * (1 << FB);
    m_dir[i] = 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NF; i++) begin
      respawn(i, 0);
      m_tmr[i]  = FD + 16 * i;
      m_left[i] = 0;
      m_esc[i]  = 0;
      m_kill[i] = 0;
    end
    m_lfsr = 16'hACE1;
  endfunction

  function automatic void model_step(bit sof, bit p, logic [10:0] rng, logic [NF-1:0] h);
    logic [15:0] mixed;
    bit          frame;
    int          samp, ypx;
    mixed = m_lfsr ^ {rng, 5'b0};
    frame = sof && !p;
    for (int i = 0; i < NF; i++) begin
      samp = (i % 2 == 1) ? int'(mixed[15:8]) : int'(mixed[7:0]);
      m_esc[i]  = 0;
      m_kill[i] = 0;
      case (m_st[i])
        0: if (frame) begin
             if (m_tmr[i] == 0) m_st[i] = 1;
             else m_tmr[i] = m_tmr[i] - 1;
           end
        1: if (h[i] && !p) begin
             m_st[i] = 2; m_left[i] = HF; m_kill[i] = 1;
           end else if (frame) begin
             m_x[i] = m_x[i] + XS;
             ypx = m_y[i] >>> FB;
             if (ypx < TOP) m_dir[i] = 1;
             else if (ypx > BOT) m_dir[i] = -1;
             else if (samp < FT) m_dir[i] = -m_dir[i];
             m_y[i] = m_y[i] + m_dir[i] * YS;
             if ((m_x[i] >>> FB) <= LEFT) begin
               respawn(i, samp);
               m_esc[i] = 1;
             end
           end
        default: if (frame) begin
             m_left[i] = m_left[i] - 1;
             if (m_left[i] == 0) respawn(i, samp);
           end
      endcase
    end
    if (sof) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < NF; i++) begin
      s.x[i*CW +: CW] = CW'(m_x[i] >>> FB);
      s.y[i*CW +: CW] = CW'(m_y[i] >>> FB);
      s.act[i]  = (m_st[i] == 1);
      s.anim[i] = (m_st[i] == 2);
      s.esc[i]  = m_esc[i];
      s.kill[i] = m_kill[i];
    end
    return s;
  endfunction

  // Drive one cycle on the falling edge and queue the response expected after the next rising edge.
  task automatic drive(input bit r, input bit s, input bit p, input logic [10:0] rng,
                       input logic [NF-1:0] h);
    @(negedge clk);
    reset = r; startOfFrame = s; pause = p; RNG = rng; hit = h;
    if (r) model_reset();
    else   model_step(s, p, rng, h);
    exp_q.push_back(model_snap());
  endtask

  task automatic frame(input bit p, input int hit_rate);
    logic [NF-1:0] h;
    for (int c = 0; c < FRAME_CYC; c++) begin
      h = '0;
      if (hit_rate > 0)
        for (int i = 0; i < NF; i++) h[i] = ($urandom_range(hit_rate - 1) == 0);
      drive(1'b0, c == 0, p, 11'($urandom), h);
    end
  endtask

  task automatic wait_ch0_flying();
    for (int k = 0; k < 2000 && m_st[0] != 1; k++) frame(1'b0, 0);
    checks++;
    if (m_st[0] != 1) begin
      errors++;
      $display("FAIL ch0_fly_timeout state=%0d required=1", m_st[0]);
    end
  endtask

  // Hit channel 0 in the same cycle as a frame strobe.
  task automatic hit_on_sof();
    wait_ch0_flying();
    drive(1'b0, 1'b1, 1'b0, 11'($urandom), NF'(1));
  endtask

  task automatic check_reset_now();
    snap_t a, e;
    drive(1'b1, 1'b0, 1'b0, 11'd0, '0);
    #1;
    a = {topLeftX, topLeftY, flyerActive, flyerHitAnim, escapedPulse, killedPulse};
    e = model_snap();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL async_reset got=%h required=%h", a, e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {topLeftX, topLeftY, flyerActive, flyerHitAnim, escapedPulse, killedPulse};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs t=%0t got=%h required=%h", $time, mon_a, mon_e);
        end
        if (escapedPulse[0]) esc0_seen++;
        if (killedPulse[0])  kill0_seen++;
        for (int i = 0; i < NF; i++)
          if (flyerActive[i] && $signed(topLeftY[i*CW +: CW]) > BOT + 2 &&
              (SY + i * YSTEP) <= BOT) y_over++;
      end
    end
  end

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; pause = 1'b0; RNG = '0; hit = '0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 11'd0, '0);
    repeat (520) frame(1'b0, 0);
    repeat (50)  frame(1'b1, 0);
    repeat (30)  frame(1'b0, 0);
    hit_on_sof();
    repeat (14)  frame(1'b0, 0);
    repeat (300) frame($urandom_range(9) == 0, 40);
    hit_on_sof();
    repeat (3)   frame(1'b0, 0);
    check_reset_now();
    drive(1'b1, 1'b0, 1'b0, 11'd0, '0);
    repeat (150) frame(1'b0, 0);
    repeat (3)   drive(1'b0, 1'b0, 1'b0, 11'd0, '0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    checks++;
    if (esc0_seen < 1) begin
      errors++;
      $display("FAIL escape_pulse_ch0 count=%0d required>=1", esc0_seen);
    end
    checks++;
    if (kill0_seen < 2) begin
      errors++;
      $display("FAIL killed_pulse_ch0 count=%0d required>=2", kill0_seen);
    end
    checks++;
    if (y_over != 0) begin
      errors++;
      $display("FAIL y_bound overshoots=%0d required=0", y_over);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
